// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: sizes, inverse S-box and InvShiftRows.
package aes_pkg;

    localparam int unsigned BLOCK_LENGTH = 128;
    localparam int unsigned NB           = 4;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned NBYTES       = BLOCK_LENGTH / BYTE_W;

    // Byte 0 is the most significant byte; byte index = row + 4*column.
    typedef logic [0:NBYTES-1][BYTE_W-1:0] state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Row r rotates right by r byte positions: out[r][c] = in[r][(c - r) mod 4].
    function automatic state_t inv_shift_rows(input state_t state);
        state_t res;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < NB; r++) begin
                res[4'(r + NB * c)] = state[4'(r + NB * ((c + NB - r) % NB))];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/inv_sub_bytes.sv
// InvSubBytes: 16 parallel inverse S-box lookups, shared by all inverse rounds.
module inv_sub_bytes
    import aes_pkg::*;
(
    input  logic [BLOCK_LENGTH-1:0] state,
    output logic [BLOCK_LENGTH-1:0] result
);

    // One table lookup per byte lane.
    for (genvar i = 0; i < NBYTES; i++) begin : g_byte
        assign result[BYTE_W*i +: BYTE_W] = INV_SBOX[state[BYTE_W*i +: BYTE_W]];
    end

endmodule

// File: rtl/key_add.sv
// AddRoundKey: bitwise XOR of state and round key.
module key_add
    import aes_pkg::*;
(
    input  logic [BLOCK_LENGTH-1:0] state,
    input  logic [BLOCK_LENGTH-1:0] key,
    output logic [BLOCK_LENGTH-1:0] result
);

    assign result = state ^ key;

endmodule

// File: rtl/inv_round_10.sv
// First decryption stage: OUT = InvSubBytes(InvShiftRows(IN ^ KEY)), 2-stage valid/ready pipeline.
module inv_round_10 #(
    parameter int unsigned BLOCK_LENGTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [BLOCK_LENGTH-1:0] IN,
    input  logic [BLOCK_LENGTH-1:0] KEY,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [BLOCK_LENGTH-1:0] OUT,
    output logic                    out_valid,
    input  logic                    out_ready
);

    import aes_pkg::*;

    logic [BLOCK_LENGTH-1:0] added;
    logic [BLOCK_LENGTH-1:0] s1_data;
    logic                    s1_valid;
    state_t                  shifted;
    logic [BLOCK_LENGTH-1:0] substituted;
    logic                    adv2;
    logic                    in_xfer;
    logic                    out_xfer;

    key_add u_key_add (
        .state  (IN),
        .key    (KEY),
        .result (added)
    );

    assign shifted = inv_shift_rows(s1_data);

    inv_sub_bytes u_inv_sub_bytes (
        .state  (shifted),
        .result (substituted)
    );

    // Stage 1 moves forward when the output register is empty or being drained.
    assign adv2     = s1_valid & (~out_valid | out_ready);
    assign in_ready = enable & (~s1_valid | adv2);
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Stage 1: register the key-added block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else if (!enable) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else if (in_xfer) begin
            s1_data  <= added;
            s1_valid <= 1'b1;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: register the substituted block; zero the output once consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OUT       <= '0;
            out_valid <= 1'b0;
        end else if (!enable) begin
            OUT       <= '0;
            out_valid <= 1'b0;
        end else if (adv2) begin
            OUT       <= substituted;
            out_valid <= 1'b1;
        end else if (out_xfer) begin
            OUT       <= '0;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inv_round_10.sv
// Self-checking bench for inv_round_10 against an arithmetic AES reference model.
module tb_inv_round_10;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [127:0] in_data;
    logic [127:0] key;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;

    int passes = 0;
    int total  = 0;
    int edges  = 0;

    logic [7:0] ref_sbox [256];

    localparam logic [127:0] C1_IN  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] ALL_52 = {16{8'h52}};

    inv_round_10 dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .IN        (in_data),
        .KEY       (key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .OUT       (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Inverse S-box from first principles: inverse affine map, then field inverse.
    task automatic build_ref_sbox();
        for (int y = 0; y < 256; y++) begin
            logic [7:0] yb;
            logic [7:0] t;
            logic [7:0] inv;
            yb  = 8'(y);
            t   = rotl8(yb, 1) ^ rotl8(yb, 3) ^ rotl8(yb, 6) ^ 8'h05;
            inv = 8'h00;
            for (int z = 1; z < 256; z++)
                if (gmul(t, 8'(z)) == 8'h01) inv = 8'(z);
            ref_sbox[y] = inv;
        end
    endtask

    function automatic logic [127:0] ref_round(input logic [127:0] ct, input logic [127:0] k);
        logic [127:0] s;
        logic [127:0] o;
        s = ct ^ k;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                int src;
                int dst;
                src = r + 4 * ((c - r + 4) % 4);
                dst = r + 4 * c;
                o[127 - 8*dst -: 8] = ref_sbox[s[127 - 8*src -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drive one cycle at the falling edge; return pre-edge in_ready/out_valid/OUT.
    task automatic step(input logic v, input logic [127:0] d, input logic [127:0] k,
                        input logic ordy, input logic en,
                        output logic rdy, output logic ov, output logic [127:0] od);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        key       = k;
        out_ready = ordy;
        enable    = en;
        #1;
        rdy = in_ready;
        ov  = out_valid;
        od  = out_data;
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic test_reset();
        #12;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
        total++; if (out_data !== 128'h0) $display("FAIL reset_out: got %h want 0", out_data); else passes++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passes++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fips_vector();
        logic rdy, ov;
        logic [127:0] od;
        step(1'b1, C1_IN, C1_KEY, 1'b1, 1'b1, rdy, ov, od);
        total++; if (rdy !== 1'b1) $display("FAIL fips_in_ready: got %b want 1", rdy); else passes++;
        total++; if (out_valid !== 1'b0) $display("FAIL fips_early_valid: got %b want 0", out_valid); else passes++;
        step(1'b0, '0, '0, 1'b1, 1'b1, rdy, ov, od);
        total++; if (out_valid !== 1'b1) $display("FAIL fips_valid: got %b want 1", out_valid); else passes++;
        total++; if (out_data !== C1_OUT) $display("FAIL fips_out: got %h want %h", out_data, C1_OUT); else passes++;
        step(1'b0, '0, '0, 1'b1, 1'b1, rdy, ov, od);
        total++; if (out_valid !== 1'b0) $display("FAIL fips_valid_1clk: got %b want 0", out_valid); else passes++;
        total++; if (out_data !== 128'h0) $display("FAIL fips_out_cleared: got %h want 0", out_data); else passes++;
    endtask

    task automatic test_key_equal();
        logic rdy, ov;
        logic [127:0] od;
        logic [127:0] k;
        for (int n = 0; n < 3; n++) begin
            k = rand128();
            step(1'b1, k, k, 1'b1, 1'b1, rdy, ov, od);
            step(1'b0, '0, '0, 1'b1, 1'b1, rdy, ov, od);
            total++; if (out_valid !== 1'b1) $display("FAIL keyeq_valid[%0d]: got %b want 1", n, out_valid); else passes++;
            total++; if (out_data !== ALL_52) $display("FAIL keyeq_out[%0d]: got %h want %h", n, out_data, ALL_52); else passes++;
        end
        step(1'b0, '0, '0, 1'b1, 1'b1, rdy, ov, od);
    endtask

    task automatic test_back_to_back();
        logic rdy, ov;
        logic [127:0] od;
        logic [127:0] blk [8];
        logic [127:0] kk [8];
        for (int i = 0; i < 8; i++) begin
            blk[i] = rand128();
            kk[i]  = rand128();
        end
        for (int i = 0; i < 11; i++) begin
            if (i < 8) step(1'b1, blk[i], kk[i], 1'b1, 1'b1, rdy, ov, od);
            else       step(1'b0, '0, '0, 1'b1, 1'b1, rdy, ov, od);
            if (i < 8) begin
                total++; if (rdy !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, rdy); else passes++;
            end
            if (i >= 2 && i < 10) begin
                total++; if (ov !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, ov); else passes++;
                total++;
                if (od !== ref_round(blk[i-2], kk[i-2]))
                    $display("FAIL b2b_out[%0d]: got %h want %h", i, od, ref_round(blk[i-2], kk[i-2]));
                else passes++;
            end else begin
                total++; if (ov !== 1'b0) $display("FAIL b2b_idle_valid[%0d]: got %b want 0", i, ov); else passes++;
            end
        end
    endtask

    task automatic test_stall();
        logic rdy, ov, ordy, v;
        logic [127:0] od;
        logic [127:0] blk [4];
        logic [127:0] kk [4];
        int sent = 0;
        int got  = 0;
        for (int i = 0; i < 4; i++) begin
            blk[i] = rand128();
            kk[i]  = rand128();
        end
        for (int i = 0; i < 20 && got < 4; i++) begin
            ordy = (i >= 6);
            v    = (sent < 4);
            step(v, v ? blk[sent] : '0, v ? kk[sent] : '0, ordy, 1'b1, rdy, ov, od);
            if (i < 6) begin
                total++;
                if (rdy !== (i < 2)) $display("FAIL stall_in_ready[%0d]: got %b want %b", i, rdy, (i < 2));
                else passes++;
            end
            if (i >= 2 && i < 6) begin
                total++;
                if (ov !== 1'b1 || od !== ref_round(blk[0], kk[0]))
                    $display("FAIL stall_hold[%0d]: got %b/%h want 1/%h", i, ov, od, ref_round(blk[0], kk[0]));
                else passes++;
            end
            if (ov && ordy) begin
                total++;
                if (od !== ref_round(blk[got], kk[got]))
                    $display("FAIL stall_order[%0d]: got %h want %h", got, od, ref_round(blk[got], kk[got]));
                else passes++;
                got++;
            end
            if (v && rdy) sent++;
        end
        total++; if (got !== 4) $display("FAIL stall_count: got %0d want 4", got); else passes++;
        total++; if (out_valid !== 1'b0) $display("FAIL stall_no_dup: got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_enable_drop();
        logic rdy, ov;
        logic [127:0] od;
        logic [127:0] c, kc;
        step(1'b1, rand128(), rand128(), 1'b1, 1'b1, rdy, ov, od);
        step(1'b1, rand128(), rand128(), 1'b1, 1'b1, rdy, ov, od);
        total++; if (out_valid !== 1'b1) $display("FAIL en_inflight: got %b want 1", out_valid); else passes++;
        step(1'b1, rand128(), rand128(), 1'b1, 1'b0, rdy, ov, od);
        total++; if (rdy !== 1'b0) $display("FAIL en_in_ready_low: got %b want 0", rdy); else passes++;
        total++; if (out_valid !== 1'b0) $display("FAIL en_flush_valid: got %b want 0", out_valid); else passes++;
        total++; if (out_data !== 128'h0) $display("FAIL en_flush_out: got %h want 0", out_data); else passes++;
        c  = rand128();
        kc = rand128();
        step(1'b1, c, kc, 1'b1, 1'b1, rdy, ov, od);
        total++; if (rdy !== 1'b1) $display("FAIL en_resume_ready: got %b want 1", rdy); else passes++;
        total++; if (out_valid !== 1'b0) $display("FAIL en_no_stale: got %b want 0", out_valid); else passes++;
        step(1'b0, '0, '0, 1'b1, 1'b1, rdy, ov, od);
        total++;
        if (out_valid !== 1'b1 || out_data !== ref_round(c, kc))
            $display("FAIL en_resume_out: got %b/%h want 1/%h", out_valid, out_data, ref_round(c, kc));
        else passes++;
        step(1'b0, '0, '0, 1'b1, 1'b1, rdy, ov, od);
        total++; if (out_valid !== 1'b0) $display("FAIL en_resume_single: got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_async_reset();
        logic rdy, ov;
        logic [127:0] od;
        logic [127:0] c, kc;
        step(1'b1, rand128(), rand128(), 1'b1, 1'b1, rdy, ov, od);
        step(1'b1, rand128(), rand128(), 1'b1, 1'b1, rdy, ov, od);
        total++; if (out_valid !== 1'b1) $display("FAIL arst_midstream: got %b want 1", out_valid); else passes++;
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", out_valid); else passes++;
        total++; if (out_data !== 128'h0) $display("FAIL arst_out: got %h want 0", out_data); else passes++;
        total++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready: got %b want 1", in_ready); else passes++;
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, '0, '0, 1'b1, 1'b1, rdy, ov, od);
        total++; if (out_valid !== 1'b0) $display("FAIL arst_lost: got %b want 0", out_valid); else passes++;
        c  = rand128();
        kc = rand128();
        step(1'b1, c, kc, 1'b1, 1'b1, rdy, ov, od);
        step(1'b0, '0, '0, 1'b1, 1'b1, rdy, ov, od);
        total++;
        if (out_valid !== 1'b1 || out_data !== ref_round(c, kc))
            $display("FAIL arst_resume: got %b/%h want 1/%h", out_valid, out_data, ref_round(c, kc));
        else passes++;
        step(1'b0, '0, '0, 1'b1, 1'b1, rdy, ov, od);
    endtask

    // Random traffic: queue of expected blocks in arrival order, each tagged with its entry edge.
    task automatic test_random();
        logic rdy, ov, v, ordy, en, exp_rdy, exp_ov;
        logic [127:0] od, d, k, prev_od;
        logic prev_stall = 1'b0;
        logic [127:0] exp_q [$];
        int           ent_q [$];
        int           e0;
        for (int i = 0; i < 400; i++) begin
            v    = (i < 390) && ($urandom_range(0, 9) < 7);
            ordy = (i >= 390) || ($urandom_range(0, 9) < 6);
            en   = (i >= 390) || ($urandom_range(0, 39) != 0);
            d    = rand128();
            k    = rand128();
            e0   = edges;
            step(v, d, k, ordy, en, rdy, ov, od);
            exp_rdy = en && (exp_q.size() < 2 || ordy);
            exp_ov  = (exp_q.size() > 0) && (ent_q[0] < e0);
            total++; if (rdy !== exp_rdy) $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, rdy, exp_rdy); else passes++;
            total++; if (ov !== exp_ov) $display("FAIL rnd_valid[%0d]: got %b want %b", i, ov, exp_ov); else passes++;
            if (exp_ov) begin
                total++; if (od !== exp_q[0]) $display("FAIL rnd_out[%0d]: got %h want %h", i, od, exp_q[0]); else passes++;
            end
            if (prev_stall) begin
                total++;
                if (ov !== 1'b1 || od !== prev_od) $display("FAIL rnd_hold[%0d]: got %b/%h want 1/%h", i, ov, od, prev_od);
                else passes++;
            end
            prev_stall = exp_ov && !ordy && en;
            prev_od    = od;
            if (!en) begin
                exp_q.delete();
                ent_q.delete();
            end else begin
                if (exp_ov && ordy) begin
                    void'(exp_q.pop_front());
                    void'(ent_q.pop_front());
                end
                if (v && exp_rdy) begin
                    exp_q.push_back(ref_round(d, k));
                    ent_q.push_back(edges);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        key       = '0;
        out_ready = 1'b0;
        build_ref_sbox();
        test_reset();
        test_fips_vector();
        test_key_equal();
        test_back_to_back();
        test_stall();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
